// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : md_sequencer
//  Purpose  : Multi-cycle multiply/divide controller for the 5-stage MIPS
//             pipeline. Owns the HI/LO registers. When idle it accepts one
//             mult/multu/div/divu/mthi/mtlo command from the E stage. It
//             computes the result at issue and holds it in pending registers.
//             A cycle counter then models the operation latency, and the
//             result is committed to HI/LO when the counter expires.
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous, active-high reset
//             start - E-stage instruction is an md command
//             op    - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 nop
//             a, b  - forwarded rs / rt operands
//             md_d  - D-stage instruction is md-class
//             busy  - operation in flight
//             stall - combinational stall request to the pipeline
//             hi,lo - HI / LO architectural registers
//  Revision : 1.0 - initial release
// ============================================================================
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;   // 0 for divide-by-zero: commit is skipped
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // --------------------------------------------------------------------------
  // Arithmetic datapath (evaluated from the E-stage operands at issue)
  // --------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b_s, div_b_u;
  logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;
  logic        b_zero;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    // Sign extension to 64 bits gives the correct two's-complement product
    // in the low 64 bits of an unsigned multiply.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    b_zero = (b == 32'd0);

    // Signed divide is done on magnitudes, then signs are restored. This
    // makes 0x80000000 / -1 give 0x80000000 with remainder 0, without
    // relying on the overflow behaviour of a native signed divide.
    abs_a   = a[31] ? (~a + 32'd1) : a;
    abs_b   = b[31] ? (~b + 32'd1) : b;
    div_b_s = b_zero ? 32'd1 : abs_b;
    div_b_u = b_zero ? 32'd1 : b;

    uq_s = abs_a / div_b_s;
    ur_s = abs_a % div_b_s;
    q_s  = (a[31] ^ b[31]) ? (~uq_s + 32'd1) : uq_s;  // truncate toward zero
    r_s  = a[31] ? (~ur_s + 32'd1) : ur_s;            // sign of dividend

    q_u = a / div_b_u;
    r_u = a % div_b_u;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
      OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              // op[1] set means a divide
              pend_wr_d = ~(op[1] & b_zero);
              cnt_d     = op[1] ? DIV_CNT : MULT_CNT;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // Any start seen here is ignored.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  // Issue from E of a mult/div (op < 4) collides with a D-stage md instruction.
  assign stall = md_d & (busy | (start & ~op[2]));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_sequencer
//  Purpose  : Directed self-checking bench for md_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        md_d;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .md_d  (md_d),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a mult/div and follow it to commit. hi/lo must hold old values
  // during the run, busy and stall must be high for exactly n cycles.
  // With inject set, a second start (div) is presented during the run.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] va, input logic [31:0] vb,
                        input int n, input logic inject,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = o; a = va; b = vb; md_d = 1'b1;
    #1;
    chk({tag, "_issue_stall"}, {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (inject && i == 1) begin
        start = 1'b1; op = 3'd2; a = 32'd5; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      #1;
      chk({tag, "_busy"},  {31'd0, busy},  32'd1);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_hold_hi"}, hi, old_hi);
      chk({tag, "_hold_lo"}, lo, old_lo);
      tick();
    end
    start = 1'b0; md_d = 1'b0;
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    tick();
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi_after"}, hi, exp_hi);
    chk({tag, "_lo_after"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0; md_d = 1'b0;
    tick(); tick();
    reset = 1'b0;
    md_d = 1'b1;
    #1;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // mthi / mtlo: immediate register writes, no busy, no stall
    start = 1'b1; op = 3'd4; a = 32'h12345678; md_d = 1'b1;
    #1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    chk("mthi_hi",   hi, 32'h12345678);
    chk("mthi_lo",   lo, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; op = 3'd5; a = 32'hCAFEBABE;
    #1;
    chk("mtlo_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    chk("mtlo_lo",   lo, 32'hCAFEBABE);
    chk("mtlo_hi",   hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // no-op opcodes leave everything alone
    start = 1'b1; op = 3'd6; a = 32'h0BADF00D; b = 32'h1;
    tick();
    start = 1'b1; op = 3'd7;
    tick();
    start = 1'b0;
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h12345678);
    chk("nop_lo", lo, 32'hCAFEBABE);

    // mult -2 * 3 = -6, with a second start injected mid-run
    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 1'b1,
           32'h12345678, 32'hCAFEBABE, 32'hFFFFFFFF, 32'hFFFFFFFA);
    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 1'b0,
           32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFE);
    // divu 100 / 7 = 14 r 2
    run_op("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0,
           32'h00000001, 32'hFFFFFFFE, 32'd2, 32'd14);
    // div -7 / 2 = -3 r -1
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 1'b0,
           32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD);
    // div by zero: full duration, hi/lo unchanged
    run_op("div_zero", 3'd2, 32'd5, 32'd0, 10, 1'b0,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
    // signed overflow case
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000000, 32'h80000000);

    // reset for two cycles in the middle of a divu: no commit afterwards
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rrun_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rrun_busy0", {31'd0, busy}, 32'd0);
    chk("rrun_hi0", hi, 32'd0);
    chk("rrun_lo0", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("rrun_busy_late", {31'd0, busy}, 32'd0);
    chk("rrun_hi_late", hi, 32'd0);
    chk("rrun_lo_late", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
